// File: rtl/record_bcd_converter_if.sv
// ---------------------------------------------------------------------------
// record_bcd_converter_if
//   Groups the request/result signals of the binary-to-BCD converter so the
//   converter and whatever drives it connect through one bundle.
//
//   Signals
//     start       request conversion of bin_in (driven by the requester)
//     bin_in      binary value to convert      (driven by the requester)
//     busy        conversion in progress        (driven by the converter)
//     done        one-cycle completion pulse    (driven by the converter)
//     digits_out  packed BCD result, units in [3:0] (driven by the converter)
//     ovf         last value was clamped to the saturation limit
//
//   Modports
//     master  requester side (drives start/bin_in, observes results)
//     slave   converter side (observes start/bin_in, drives results)
// ---------------------------------------------------------------------------
interface record_bcd_converter_if #(
  parameter int WIDTH = 24,
  parameter int NDIG  = 7
);

  logic                start;
  logic [WIDTH-1:0]    bin_in;
  logic                busy;
  logic                done;
  logic [4*NDIG-1:0]   digits_out;
  logic                ovf;

  // Requester view: issues conversions and reads back the digit snapshot.
  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  digits_out,
    input  ovf
  );

  // Converter view: accepts conversions and publishes the digit snapshot.
  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output digits_out,
    output ovf
  );

endinterface

// File: rtl/record_bcd_converter.sv
// ---------------------------------------------------------------------------
// record_bcd_converter
//   Iterative double-dabble binary-to-BCD converter for the VGA digit
//   renderer. One input bit is consumed per clock, so a conversion takes
//   WIDTH cycles. The published digits are a snapshot that only changes on
//   the done pulse (or reset), so a frame never shows a half-built number.
//
//   Parameters
//     WIDTH    binary input width
//     NDIG     number of BCD digits produced
//     MAX_VAL  saturation limit, must be below 10**NDIG
//
//   Ports
//     clk    system clock
//     rst_n  synchronous active-low reset
//     bus    record_bcd_converter_if.slave
//              start/bin_in in, busy/done/digits_out/ovf out
//
//   Build option
//     LEADING_ZERO_BLANK_EN  when defined, zero digits above the most
//                            significant non-zero digit are published as
//                            4'hF (drawn blank); digit 0 is never blanked.
//                            Timing and handshake are the same either way.
// ---------------------------------------------------------------------------
module record_bcd_converter #(
  parameter int WIDTH   = 24,
  parameter int NDIG    = 7,
  parameter int MAX_VAL = 9_999_999
) (
  input  logic                    clk,
  input  logic                    rst_n,
  record_bcd_converter_if.slave    bus
);

  localparam int               CW      = $clog2(WIDTH + 1);
  localparam int               BW      = 4 * NDIG;
  localparam logic [WIDTH-1:0] MAX_BIN = WIDTH'(MAX_VAL);
  localparam logic [CW-1:0]    CNT_LD  = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Registered state
  state_t            r_state;
  logic [WIDTH-1:0]  r_shiftReg;
  logic [BW-1:0]     r_scratch;
  logic [CW-1:0]     r_cnt;
  logic              r_satFlag;
  logic              r_busy;
  logic              r_done;
  logic [BW-1:0]     r_digits;
  logic              r_ovf;

  // Combinational next values and datapath intermediates
  state_t            w_nextState;
  logic [WIDTH-1:0]  w_nextShiftReg;
  logic [BW-1:0]     w_nextScratch;
  logic [CW-1:0]     w_nextCnt;
  logic              w_nextSatFlag;
  logic              w_nextBusy;
  logic              w_nextDone;
  logic [BW-1:0]     w_nextDigits;
  logic              w_nextOvf;
  logic [BW-1:0]     w_adjusted;
  logic [BW-1:0]     w_postShift;
  logic [BW-1:0]     w_display;
  logic              w_overLimit;
`ifdef LEADING_ZERO_BLANK_EN
  logic              w_leading;
`endif

  // Values above the limit are clamped so the digits can never need more
  // than NDIG places; the clamp is remembered so ovf can report it.
  assign w_overLimit = (bus.bin_in > MAX_BIN);

  // Double-dabble correction: any digit that would reach 10 or more after
  // the coming doubling is pre-biased by 3 so the shift carries into the
  // next digit. All digits are corrected in parallel.
  always_comb begin
    w_adjusted = r_scratch;
    for (int d = 0; d < NDIG; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5) begin
        w_adjusted[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  // The scratch digits after this cycle's shift: corrected digits move up
  // one bit and take in the top bit of the binary shift register.
  assign w_postShift = {w_adjusted[BW-2:0], r_shiftReg[WIDTH-1]};

  // Digit snapshot as it will be published. With blanking enabled, zero
  // digits are replaced by 4'hF while scanning down from the top, stopping
  // at the first non-zero digit; digit 0 always shows its true value.
  always_comb begin
    w_display = w_postShift;
`ifdef LEADING_ZERO_BLANK_EN
    w_leading = 1'b1;
    for (int d = NDIG - 1; d >= 1; d--) begin
      if (w_leading && (w_postShift[4*d +: 4] == 4'd0)) begin
        w_display[4*d +: 4] = 4'hF;
      end else begin
        w_leading = 1'b0;
      end
    end
`endif
  end

  // Next-state and output logic. Everything holds by default and done is a
  // pulse, so it falls back to 0 unless the final shift happens this cycle.
  // Because the FSM is back in IDLE during the done cycle, a start seen in
  // that cycle is accepted, which gives back-to-back conversions.
  always_comb begin
    w_nextState    = r_state;
    w_nextShiftReg = r_shiftReg;
    w_nextScratch  = r_scratch;
    w_nextCnt      = r_cnt;
    w_nextSatFlag  = r_satFlag;
    w_nextBusy     = r_busy;
    w_nextDone     = 1'b0;
    w_nextDigits   = r_digits;
    w_nextOvf      = r_ovf;

    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_nextShiftReg = w_overLimit ? MAX_BIN : bus.bin_in;
          w_nextScratch  = '0;
          w_nextSatFlag  = w_overLimit;
          w_nextCnt      = CNT_LD;
          w_nextBusy     = 1'b1;
          w_nextState    = SHIFT;
        end
      end

      SHIFT: begin
        w_nextScratch  = w_postShift;
        w_nextShiftReg = {r_shiftReg[WIDTH-2:0], 1'b0};
        w_nextCnt      = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_nextDigits = w_display;
          w_nextOvf    = r_satFlag;
          w_nextDone   = 1'b1;
          w_nextBusy   = 1'b0;
          w_nextState  = IDLE;
        end
      end

      default: begin
        w_nextState = IDLE;
        w_nextBusy  = 1'b0;
      end
    endcase
  end

  // State register. Reset is synchronous and takes priority over a start in
  // the same cycle; resetting mid-conversion abandons it without a done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shiftReg <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_satFlag  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_digits   <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_shiftReg <= w_nextShiftReg;
      r_scratch  <= w_nextScratch;
      r_cnt      <= w_nextCnt;
      r_satFlag  <= w_nextSatFlag;
      r_busy     <= w_nextBusy;
      r_done     <= w_nextDone;
      r_digits   <= w_nextDigits;
      r_ovf      <= w_nextOvf;
    end
  end

  // All outputs come straight from registers.
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.digits_out = r_digits;
  assign bus.ovf        = r_ovf;

endmodule

// File: tb/tb_record_bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_record_bcd_converter
//   Directed bench for record_bcd_converter at default parameters
//   (WIDTH=24, NDIG=7, MAX_VAL=9_999_999). Expected digit patterns are
//   hand-computed; the blank-code variants apply when LEADING_ZERO_BLANK_EN
//   is defined for the build.
// ---------------------------------------------------------------------------
module tb_record_bcd_converter;

  localparam int WIDTH = 24;
  localparam int NDIG  = 7;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [27:0] EXP_0    = 28'hFFFFFF0;
  localparam logic [27:0] EXP_305  = 28'hFFFF305;
  localparam logic [27:0] EXP_42   = 28'hFFFFF42;
  localparam logic [27:0] EXP_500  = 28'hFFFF500;
  localparam logic [27:0] EXP_123  = 28'hFFFF123;
  localparam logic [27:0] EXP_456  = 28'hFFFF456;
  localparam logic [27:0] EXP_999  = 28'hFFFF999;
`else
  localparam logic [27:0] EXP_0    = 28'h0000000;
  localparam logic [27:0] EXP_305  = 28'h0000305;
  localparam logic [27:0] EXP_42   = 28'h0000042;
  localparam logic [27:0] EXP_500  = 28'h0000500;
  localparam logic [27:0] EXP_123  = 28'h0000123;
  localparam logic [27:0] EXP_456  = 28'h0000456;
  localparam logic [27:0] EXP_999  = 28'h0000999;
`endif
  localparam logic [27:0] EXP_1234567 = 28'h1234567;
  localparam logic [27:0] EXP_NINES   = 28'h9999999;

  logic clk;
  logic rst_n;
  int   errCount;
  int   checkCount;

  record_bcd_converter_if #(.WIDTH(WIDTH), .NDIG(NDIG)) bus ();

  record_bcd_converter #(
    .WIDTH  (WIDTH),
    .NDIG   (NDIG),
    .MAX_VAL(9_999_999)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just after the edge, where inputs are
  // changed and outputs are sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start with the given value and wait (bounded) for done.
  // latency is the number of edges after the start edge; -1 on timeout.
  task automatic runConversion(input logic [23:0] value, output int latency);
    bus.bin_in = value;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    latency    = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.done === 1'b1) begin
        latency = k;
        break;
      end
    end
  endtask

  // Reset held for two cycles clears every output.
  task automatic test_reset();
    rst_n      = 1'b0;
    bus.start  = 1'b1;
    bus.bin_in = 24'd1234;
    step();
    step();
    checkCount++;
    if (bus.busy !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
    end
    checkCount++;
    if (bus.done !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL reset_done: got %b expected 0", bus.done);
    end
    checkCount++;
    if (bus.ovf !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL reset_ovf: got %b expected 0", bus.ovf);
    end
    checkCount++;
    if (bus.digits_out !== 28'h0000000) begin
      errCount++;
      $display("[TB] FAIL reset_digits: got %h expected 0000000", bus.digits_out);
    end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    step();
  endtask

  // Plain conversion: latency, digits, flags and a single-cycle done.
  task automatic test_basic();
    int lat;
    runConversion(24'd1_234_567, lat);
    checkCount++;
    if (lat !== 24) begin
      errCount++;
      $display("[TB] FAIL basic_latency: got %0d expected 24", lat);
    end
    checkCount++;
    if (bus.digits_out !== EXP_1234567) begin
      errCount++;
      $display("[TB] FAIL basic_digits: got %h expected %h", bus.digits_out, EXP_1234567);
    end
    checkCount++;
    if (bus.ovf !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL basic_ovf: got %b expected 0", bus.ovf);
    end
    checkCount++;
    if (bus.busy !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL basic_busy_at_done: got %b expected 0", bus.busy);
    end
    step();
    checkCount++;
    if (bus.done !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL basic_done_pulse: got %b expected 0", bus.done);
    end
  endtask

  // Zero and a value with leading zeros (blank codes when enabled).
  task automatic test_leading_zeros();
    int lat;
    runConversion(24'd0, lat);
    checkCount++;
    if (bus.digits_out !== EXP_0) begin
      errCount++;
      $display("[TB] FAIL zero_digits: got %h expected %h (latency %0d)", bus.digits_out, EXP_0, lat);
    end
    runConversion(24'd305, lat);
    checkCount++;
    if (bus.digits_out !== EXP_305) begin
      errCount++;
      $display("[TB] FAIL d305_digits: got %h expected %h (latency %0d)", bus.digits_out, EXP_305, lat);
    end
  endtask

  // Values above the limit saturate to all nines and raise ovf; the flag
  // clears on the next in-range conversion.
  task automatic test_saturation();
    int lat;
    runConversion(24'd10_000_000, lat);
    checkCount++;
    if (bus.digits_out !== EXP_NINES) begin
      errCount++;
      $display("[TB] FAIL sat_digits: got %h expected %h", bus.digits_out, EXP_NINES);
    end
    checkCount++;
    if (bus.ovf !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL sat_ovf: got %b expected 1", bus.ovf);
    end
    runConversion(24'd42, lat);
    checkCount++;
    if (bus.digits_out !== EXP_42) begin
      errCount++;
      $display("[TB] FAIL after_sat_digits: got %h expected %h", bus.digits_out, EXP_42);
    end
    checkCount++;
    if (bus.ovf !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL after_sat_ovf: got %b expected 0", bus.ovf);
    end
  endtask

  // A start raised mid-conversion (with a new bin_in) must be ignored.
  task automatic test_ignored_start();
    int          doneCount;
    int          firstDone;
    logic [27:0] captured;
    doneCount  = 0;
    firstDone  = -1;
    captured   = '0;
    bus.bin_in = 24'd500;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin
        bus.start  = 1'b1;
        bus.bin_in = 24'd777;
      end else if (k == 6) begin
        bus.start  = 1'b0;
      end
      step();
      if (bus.done === 1'b1) begin
        doneCount++;
        if (firstDone < 0) begin
          firstDone = k;
          captured  = bus.digits_out;
        end
      end
    end
    checkCount++;
    if (doneCount !== 1) begin
      errCount++;
      $display("[TB] FAIL ignore_done_count: got %0d expected 1", doneCount);
    end
    checkCount++;
    if (firstDone !== 24) begin
      errCount++;
      $display("[TB] FAIL ignore_latency: got %0d expected 24", firstDone);
    end
    checkCount++;
    if (captured !== EXP_500) begin
      errCount++;
      $display("[TB] FAIL ignore_digits: got %h expected %h", captured, EXP_500);
    end
    checkCount++;
    if (bus.digits_out !== EXP_500) begin
      errCount++;
      $display("[TB] FAIL ignore_digits_stable: got %h expected %h", bus.digits_out, EXP_500);
    end
  endtask

  // Start asserted during the done cycle is accepted immediately.
  task automatic test_back_to_back();
    int lat;
    int lat2;
    runConversion(24'd123, lat);
    checkCount++;
    if (lat !== 24 || bus.digits_out !== EXP_123) begin
      errCount++;
      $display("[TB] FAIL b2b_first: got latency %0d digits %h expected 24 %h", lat, bus.digits_out, EXP_123);
    end
    bus.bin_in = 24'd456;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    checkCount++;
    if (bus.busy !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL b2b_accept_busy: got %b expected 1", bus.busy);
    end
    lat2 = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.done === 1'b1) begin
        lat2 = k;
        break;
      end
    end
    checkCount++;
    if (lat2 !== 24) begin
      errCount++;
      $display("[TB] FAIL b2b_latency: got %0d expected 24", lat2);
    end
    checkCount++;
    if (bus.digits_out !== EXP_456) begin
      errCount++;
      $display("[TB] FAIL b2b_digits: got %h expected %h", bus.digits_out, EXP_456);
    end
  endtask

  // Reset during a conversion aborts it and clears outputs; the next
  // conversion works normally. A saturated run first sets ovf=1 and
  // nonzero digits so the clearing is visible.
  task automatic test_reset_abort();
    int lat;
    int sawDone;
    runConversion(24'd16_777_215, lat);
    checkCount++;
    if (bus.ovf !== 1'b1 || bus.digits_out !== EXP_NINES) begin
      errCount++;
      $display("[TB] FAIL max_input: got ovf %b digits %h expected 1 %h", bus.ovf, bus.digits_out, EXP_NINES);
    end
    bus.bin_in = 24'd999;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkCount++;
    if (bus.busy !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy);
    end
    checkCount++;
    if (bus.digits_out !== 28'h0000000) begin
      errCount++;
      $display("[TB] FAIL abort_digits: got %h expected 0000000", bus.digits_out);
    end
    checkCount++;
    if (bus.ovf !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL abort_ovf: got %b expected 0", bus.ovf);
    end
    sawDone = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.done === 1'b1) sawDone++;
      step();
    end
    checkCount++;
    if (sawDone !== 0) begin
      errCount++;
      $display("[TB] FAIL abort_no_done: got %0d done pulses expected 0", sawDone);
    end
    runConversion(24'd999, lat);
    checkCount++;
    if (lat !== 24) begin
      errCount++;
      $display("[TB] FAIL abort_retry_latency: got %0d expected 24", lat);
    end
    checkCount++;
    if (bus.digits_out !== EXP_999) begin
      errCount++;
      $display("[TB] FAIL abort_retry_digits: got %h expected %h", bus.digits_out, EXP_999);
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    errCount   = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    #1;
    $display("[TB] starting record_bcd_converter scenarios");
    test_reset();
    test_basic();
    test_leading_zeros();
    test_saturation();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
